// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 2-flop synchronized input, mid-bit sampling; UART_RX_FRAME_ERR_EN enables stop-bit framing errors
module uart_rx #(
    parameter int CLKS_PER_BIT = 10415
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] CLEANUP = 3'd4;

    logic          meta_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          dv_q, dv_d;
    logic          err_q, err_d;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            meta_q <= i_Rx_Serial;
            rx_s_q <= meta_q;
        end
    end

    // Frame sequencing: start bit checked at mid-bit, data and stop sampled one bit period apart
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s_q ? IDLE : START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 1'b1;
                    state_d        = (idx_q == 3'd7) ? STOP : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = CLEANUP;
`ifdef UART_RX_FRAME_ERR_EN
                    dv_d    = rx_s_q;
                    err_d   = !rx_s_q;
                    byte_d  = rx_s_q ? shift_q : byte_q;
`else
                    dv_d    = 1'b1;
                    byte_d  = shift_q;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEANUP: state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Rx_Err    = err_q;
    assign o_Rx_Active = (state_q == START) || (state_q == DATA) || (state_q == STOP);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus checked every cycle against a timing/queue model of the receiver
module tb_uart_rx;
    localparam int C = 16;
    localparam int H = (C - 1) / 2;
    localparam int L = 3 + H + 9 * C;
`ifdef UART_RX_FRAME_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv, act, err;
    logic [7:0] byte_o;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .i_Rx_Serial(rx),
        .o_Rx_DV(dv),
        .o_Rx_Byte(byte_o),
        .o_Rx_Active(act),
        .o_Rx_Err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e0;
        int         last;
        bit         frame;
        bit         ok;
        logic [7:0] b;
    } rec_t;

    rec_t       q[$];
    logic [7:0] dv_log[$];
    logic [7:0] exp_byte = 8'h00;
    int         cyc = 0, checks = 0, errors = 0, dv_cnt = 0, err_cnt = 0, dv_cyc = -1;
    bit         e_dv, e_err, e_act;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h want %0h", n, cyc, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: a frame whose start falls before edge e0 delivers at e0+L, active e0+2..e0+L-1;
    // a rejected low pulse is active for half a bit only.
    initial forever begin
        @(posedge clk);
        #1;
        e_dv = 0;
        e_err = 0;
        e_act = 0;
        foreach (q[i]) begin
            if (cyc >= q[i].e0 + 2 && cyc <= q[i].last) e_act = 1;
            if (q[i].frame && cyc == q[i].e0 + L) begin
                if (q[i].ok || !FE) begin
                    e_dv = 1;
                    exp_byte = q[i].b;
                end else begin
                    e_err = 1;
                end
            end
        end
        while (q.size() > 0 && cyc >= (q[0].frame ? q[0].e0 + L : q[0].last)) void'(q.pop_front());
        chk("dv", dv, e_dv);
        chk("err", err, e_err);
        chk("active", act, e_act);
        chk("byte", byte_o, exp_byte);
        if (dv) begin
            dv_cnt++;
            dv_cyc = cyc;
            dv_log.push_back(byte_o);
        end
        if (err) err_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; abort_bit >= 0 pulses reset partway through that frame bit
    task automatic send(input logic [7:0] b, input bit stop, input int abort_bit = -1);
        logic [9:0] f;
        int         e0;
        f = {stop, b, 1'b0};
        e0 = cyc + 1;
        q.push_back('{e0: e0, last: e0 + L - 1, frame: 1'b1, ok: stop, b: b});
        if (!stop) q.push_back('{e0: e0 + L, last: e0 + L + 2 + H, frame: 1'b0, ok: 1'b0, b: 8'h00});
        for (int k = 0; k < 10; k++) begin
            rx = f[k];
            if (k == abort_bit) begin
                idle(C / 2);
                rst_n = 1'b0;
                rx = 1'b1;
                q.delete();
                exp_byte = 8'h00;
                idle(3);
                rst_n = 1'b1;
                idle(2);
                return;
            end
            idle(C);
        end
        rx = 1'b1;
        if (!stop) idle(C);
    endtask

    task automatic glitch(input int n);
        q.push_back('{e0: cyc + 1, last: cyc + 3 + H, frame: 1'b0, ok: 1'b0, b: 8'h00});
        rx = 1'b0;
        idle(n);
        rx = 1'b1;
        idle(2 * C);
    endtask

    initial begin
        int         e0, n0, m0;
        logic [7:0] b;
        idle(3);
        chk("rst_dv", dv, 0);
        chk("rst_byte", byte_o, 8'h00);
        chk("rst_active", act, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        idle(4);

        e0 = cyc + 1;
        send(8'hA5, 1'b1);
        idle(5);
        chk("a5_dvcnt", dv_cnt, 1);
        chk("a5_byte", byte_o, 8'hA5);
        chk("a5_latency", dv_cyc - e0, 154);
        chk("a5_active", act, 0);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        idle(5);
        chk("b2b_dvcnt", dv_cnt, 3);
        chk("b2b_first", dv_log[1], 8'h00);
        chk("b2b_second", dv_log[2], 8'hFF);

        glitch(5);
        chk("glitch_dvcnt", dv_cnt, 3);
        chk("glitch_errcnt", err_cnt, 0);
        chk("glitch_active", act, 0);

        send(8'h3C, 1'b0);
        idle(2 * C);
        chk("badstop_dvcnt", dv_cnt, FE ? 3 : 4);
        chk("badstop_errcnt", err_cnt, FE ? 1 : 0);
        chk("badstop_byte", byte_o, FE ? 8'hFF : 8'h3C);

        n0 = dv_cnt;
        send(8'h81, 1'b1, 5);
        chk("abort_byte", byte_o, 8'h00);
        chk("abort_active", act, 0);
        send(8'h5A, 1'b1);
        idle(5);
        chk("abort_dvcnt", dv_cnt, n0 + 1);
        chk("abort_next_byte", byte_o, 8'h5A);

        send(8'h37, 1'b1);
        idle(5);
        chk("loop_byte", byte_o, 8'h37);

        n0 = dv_cnt;
        m0 = 0;
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                glitch($urandom_range(1, H + 1));
            end else if ($urandom_range(0, 4) == 0) begin
                send(b, 1'b0);
                if (!FE) m0++;
            end else begin
                send(b, 1'b1);
                m0++;
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 40));
        end
        idle(2 * C);
        chk("rand_dvcnt", dv_cnt - n0, m0);
        chk("model_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog cyc %0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
